// File: rtl/tank_level_ctrl.sv
// Multi-channel tank fill controller: synchronised and debounced level sensors, latched errors (LVL_DEBOUNCE_EN selects the debounce stage).
// Latency: level change reaches pump DEB_CYC+4 edges later (4 without debounce), fault_in 3 edges. No backpressure.
// Outputs pump/err are decoded from per-channel state, err_code is registered; reset forces all pumps off asynchronously.
module tank_level_ctrl #(
    parameter int N_CH    = 2,
    parameter int LVL_W   = 3,
    parameter int DEB_CYC = 4,
    parameter int FILL_TO = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [N_CH*LVL_W-1:0]   lvl,
    input  logic [N_CH-1:0]         fault_in,
    input  logic [N_CH-1:0]         err_clr,
    output logic [N_CH-1:0]         pump,
    output logic [N_CH-1:0]         err,
    output logic [2*N_CH-1:0]       err_code
);
    localparam int TO_W  = $clog2(FILL_TO);
    localparam int DEB_W = $clog2(DEB_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_HOLD, ST_ERROR} state_t;

    if (N_CH < 1 || N_CH > 8 || LVL_W < 2 || LVL_W > 8 || DEB_CYC < 1 || FILL_TO < 2 || DEB_W < 1) begin : g_param_chk
        $error("tank_level_ctrl: parameter out of range");
    end

`ifdef LVL_DEBOUNCE_EN
    // Synchroniser output is only meaningful from edge 3; the first real sample seeds every candidate.
    logic [1:0] warm;
    logic       seeded;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm   <= '0;
            seeded <= 1'b0;
        end else begin
            warm   <= {warm[0], 1'b1};
            seeded <= warm[1];
        end
    end
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [LVL_W-1:0] lvl_s1, lvl_s2, lvl_q, lvl_inc;
        logic             fault_s1, fault_s2, lvl_vld, lvl_ok;
        state_t           state, state_nxt;
        logic [1:0]       code, code_nxt;
        logic [TO_W-1:0]  to_cnt, to_cnt_nxt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lvl_s1   <= '0;
                lvl_s2   <= '0;
                fault_s1 <= 1'b0;
                fault_s2 <= 1'b0;
            end else begin
                lvl_s1   <= lvl[k*LVL_W +: LVL_W];
                lvl_s2   <= lvl_s1;
                fault_s1 <= fault_in[k];
                fault_s2 <= fault_s1;
            end
        end

`ifdef LVL_DEBOUNCE_EN
        logic [LVL_W-1:0] cand;
        logic [DEB_W-1:0] deb_cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cand    <= '0;
                deb_cnt <= '0;
                lvl_q   <= '0;
                lvl_vld <= 1'b0;
            end else if (warm[1]) begin
                if (!seeded || lvl_s2 != cand) begin
                    cand    <= lvl_s2;
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
                    lvl_q   <= cand;
                    lvl_vld <= 1'b1;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end
        end
`else
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lvl_q   <= '0;
                lvl_vld <= 1'b0;
            end else begin
                lvl_q   <= lvl_s2;
                lvl_vld <= 1'b1;
            end
        end
`endif

        // Thermometer code: adding one only carries into the lowest zero, so no overlap remains.
        assign lvl_inc = lvl_q + LVL_W'(1);
        assign lvl_ok  = ((lvl_q & lvl_inc) == '0);

        always_comb begin
            state_nxt  = state;
            code_nxt   = code;
            to_cnt_nxt = to_cnt;
            if (state != ST_ERROR && fault_s2) begin
                state_nxt = ST_ERROR;
                code_nxt  = 2'b01;
            end else if (state != ST_ERROR && lvl_vld && !lvl_ok) begin
                state_nxt = ST_ERROR;
                code_nxt  = 2'b10;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (en && lvl_vld) begin
                            state_nxt  = lvl_q[0] ? ST_HOLD : ST_FILL;
                            to_cnt_nxt = '0;
                        end
                    end
                    ST_FILL: begin
                        if (!lvl_q[LVL_W-1] && to_cnt == TO_W'(FILL_TO - 1)) begin
                            state_nxt = ST_ERROR;
                            code_nxt  = 2'b11;
                        end else if (!en) begin
                            state_nxt = ST_IDLE;
                        end else if (lvl_q[LVL_W-1]) begin
                            state_nxt = ST_HOLD;
                        end else begin
                            to_cnt_nxt = to_cnt + TO_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (!en) begin
                            state_nxt = ST_IDLE;
                        end else if (!lvl_q[0]) begin
                            state_nxt  = ST_FILL;
                            to_cnt_nxt = '0;
                        end
                    end
                    ST_ERROR: begin
                        if (err_clr[k] && !fault_s2 && lvl_ok) begin
                            state_nxt = ST_IDLE;
                            code_nxt  = 2'b00;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state  <= ST_IDLE;
                code   <= 2'b00;
                to_cnt <= '0;
            end else begin
                state  <= state_nxt;
                code   <= code_nxt;
                to_cnt <= to_cnt_nxt;
            end
        end

        assign pump[k]            = (state == ST_FILL);
        assign err[k]             = (state == ST_ERROR);
        assign err_code[2*k +: 2] = code;
    end
endmodule
